rx_elastic_nrzi: RTL
====================

# rx_elastic_nrzi

Receive-side stage directly downstream of the USB2 clock/data recovery block. It accepts the recovered bit stream, which carries 0, 1 or 2 bits per cycle as signalled by the recovery block's `add`/`drop` flags, and buffers it in a small elastic bit FIFO. It drains the FIFO at exactly one bit per cycle, then NRZI-decodes and bit-unstuffs the stream. It emits decoded data bits with a valid strobe, plus sticky overflow, underflow and stuff-error flags, to the downstream byte assembler.

## Interface
- `DEPTH`, 16: elastic buffer capacity in bits; power of two, ≥ 8.
- `START_LEVEL`, 8: fill level required before draining starts; must be < `DEPTH`.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `rx_en`  in  1  receive enable; low flushes the block.
- `crd`  in  1  recovered bit.
- `add`  in  1  two bits this cycle, both equal to `crd`.
- `drop`  in  1  no bit this cycle.
- `dout`  out  1  decoded, unstuffed data bit.
- `dout_valid`  out  1  `dout` is valid this cycle.
- `stuff_err`  out  1  sticky; a one followed six consecutive decoded ones.
- `overflow`  out  1  sticky; a write was discarded because the buffer was full.
- `underflow`  out  1  sticky; a pop was needed while the buffer was empty.
- `level`  out  $clog2(DEPTH+1)  current buffer occupancy in bits.

## Operation
- Write count `n` each cycle while `rx_en` is high:
  - `drop` high and `add` low: `n` = 0.
  - `add` high and `drop` low: `n` = 2.
  - Otherwise, including `add` and `drop` both high: `n` = 1.
- Buffer:
  - Circular, with a read pointer and a write pointer that wrap modulo `DEPTH`.
  - Only the first `DEPTH-level+pop` bits of a write are stored.
  - Any discarded bit sets `overflow`.
- States:
  - IDLE: `rx_en` low.
  - FILL: `rx_en` high and not yet draining.
  - RUN: draining.
- Transitions:
  - IDLE→FILL when `rx_en` is high.
  - FILL→RUN when `level` ≥ `START_LEVEL`. The pop begins in that same cycle.
  - RUN→FILL when `level` is 0. That cycle does not pop and sets `underflow`.
  - Any state→IDLE when `rx_en` is low.
- `pop` = 1 in RUN with `level` > 0, and in FILL in the cycle it leaves for RUN.
- `level_next` = min(`DEPTH`, `level` + `n` − `pop`). A pop always uses the stored level, never same-cycle write data.
- NRZI decode: decoded = ~(bit ^ prev). `prev` is updated with every popped raw bit and resets to 1 (J/idle).
- Bit unstuff: a ones counter of 0..6 counts decoded ones and clears on any zero. When the counter is 6, the next popped bit is handled as follows:
  - Decoded 0: stuffed bit. It is discarded, so `dout_valid` is 0 for it, and the counter clears.
  - Decoded 1: `stuff_err` sets, the bit is discarded, and the counter clears.
- IDLE behaviour:
  - Pointers, `level`, `prev`=1, the ones counter, and all sticky flags clear.
  - No writes occur and `dout_valid` is 0.

## Timing
- Reset, synchronous: `dout`=0, `dout_valid`=0, `stuff_err`=0, `overflow`=0, `underflow`=0, `level`=0. State is IDLE, `prev`=1, counter=0, pointers=0.
- Reset asserted mid-RUN returns everything to the reset values at the next edge. Buffer contents are discarded.
- Storage is registered. A bit written in cycle t is poppable from cycle t+1.
- `dout`/`dout_valid` are registered. A bit popped in cycle t appears in cycle t+1.
- Sticky flags assert the cycle after the triggering event. They hold until `rx_en` is low or `reset` is high.
- With steady single-bit input, the first `dout_valid` comes `START_LEVEL`+1 cycles after `rx_en` rises.
- With `rx_en` low in cycle t, IDLE and cleared state are visible in cycle t+1. A pop in cycle t still emits its `dout` in t+1; `dout_valid` in t+2 is 0.

## Test plan
1. Reset, then `rx_en`=1 with `crd` alternating 0/1 each cycle and no `add`/`drop`:
   - `level` reaches 8 and then stays at 8.
   - `dout_valid` first rises 9 cycles after `rx_en`.
   - `dout`=0 on every valid cycle; all flags stay 0.
2. Hold `crd`=1 constantly (decodes to all ones): six `dout_valid`=1 bits with `dout`=1, then a cycle with `dout_valid`=0 and `stuff_err`=1 the following cycle.
3. Raw stream decoding to 1111110 then 1: six valid ones, one `dout_valid`=0 gap for the stuffed zero, then a valid 1; `stuff_err` stays 0.
4. In RUN at `level`=8, one `add` cycle: `level` steps to 9 and holds. Then one `drop` cycle: `level` returns to 8. The output bit order is preserved.
5. In RUN, `add` held for 10 cycles: `level` saturates at 16 and `overflow`=1. Then `drop` held: `level` decrements to 0, `underflow`=1, state returns to FILL, and `dout_valid` stops.
6. Mid-RUN, assert `reset` for one cycle: the next cycle shows all outputs 0 and `level`=0. Afterwards, `rx_en` low for one cycle clears the sticky flags and `level`.

Source files
------------

// File: rtl/rx_elastic_nrzi.sv
// rx_elastic_nrzi: elastic bit buffer between the USB2 clock/data recovery
// block and the byte assembler. Absorbs 0/1/2 recovered bits per cycle,
// drains exactly one bit per cycle once primed, then NRZI-decodes and
// removes stuffed bits. dbg_state exposes the fill/drain FSM.
//
// Output handshake: dout_valid is a one-cycle strobe with no ready; the
// consumer must take dout on every cycle dout_valid is high.
module rx_elastic_nrzi #(
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rx_en,
  input  logic                         crd,
  input  logic                         add,
  input  logic                         drop,
  output logic                         dout,
  output logic                         dout_valid,
  output logic                         stuff_err,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [1:0]                   dbg_state
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW:0]   DEPTH_W = (LW+1)'(DEPTH);
  localparam logic [LW-1:0] START_W = LW'(START_LEVEL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [DEPTH-1:0] mem;
  logic [PW-1:0]   rptr, wptr, wptr_p1;
  logic            prev;
  logic [2:0]      ones;
  logic [1:0]      n, stored;
  logic            pop, under_evt, over_evt;
  logic [LW:0]     room;
  logic [LW-1:0]   level_next;
  logic            raw, dec;

  assign dbg_state = state;

  // Bits offered by the recovery block this cycle (add and drop together count as one).
  always_comb begin
    n = 2'd0;
    if (rx_en) begin
      if (drop && !add)      n = 2'd0;
      else if (add && !drop) n = 2'd2;
      else                   n = 2'd1;
    end
  end

  // Fill/drain FSM: decides the pop and the underflow event from the stored level.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    under_evt  = 1'b0;
    if (!rx_en) begin
      // A drain already under way still delivers its bit while flushing.
      state_next = IDLE;
      pop        = (state == RUN) && (level != '0);
    end else if (state == RUN) begin
      if (level == '0) begin
        state_next = FILL;
        under_evt  = 1'b1;
      end else begin
        pop = 1'b1;
      end
    end else if (level >= START_W) begin
      state_next = RUN;
      pop        = 1'b1;
    end else begin
      state_next = FILL;
    end
  end

  // Buffer arithmetic: room freed by this cycle's pop is available to the write.
  always_comb begin
    room       = DEPTH_W - {1'b0, level} + {{LW{1'b0}}, pop};
    stored     = n;
    over_evt   = 1'b0;
    if ({{(LW-1){1'b0}}, n} > room) begin
      stored   = room[1:0];
      over_evt = 1'b1;
    end
    level_next = level + LW'(stored) - LW'(pop);
    wptr_p1    = wptr + PW'(1);
    raw        = mem[rptr];
    dec        = ~(raw ^ prev);
  end

  // Bit storage; contents are don't-care outside the valid window so no reset.
  always_ff @(posedge clock) begin
    if (!reset && rx_en) begin
      if (stored != 2'd0) mem[wptr]    <= crd;
      if (stored == 2'd2) mem[wptr_p1] <= crd;
    end
  end

  // State, pointers, NRZI/unstuff path and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rptr       <= '0;
      wptr       <= '0;
      level      <= '0;
      prev       <= 1'b1;
      ones       <= 3'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      stuff_err  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_next;
      dout_valid <= 1'b0;
      if (pop) begin
        dout <= dec;
        prev <= raw;
        if (ones == 3'd6) begin
          // Bit after six ones is never data: a stuffed zero or an error.
          ones <= 3'd0;
          if (dec) stuff_err <= 1'b1;
        end else begin
          dout_valid <= 1'b1;
          ones       <= dec ? ones + 3'd1 : 3'd0;
        end
      end
      if (rx_en) begin
        rptr  <= rptr + PW'(pop);
        wptr  <= wptr + PW'(stored);
        level <= level_next;
        if (over_evt)  overflow  <= 1'b1;
        if (under_evt) underflow <= 1'b1;
      end else begin
        rptr      <= '0;
        wptr      <= '0;
        level     <= '0;
        prev      <= 1'b1;
        ones      <= 3'd0;
        stuff_err <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
    end
  end

endmodule
